// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, function codes and flag bundle.
//   ALU_N / ALU_M : default operand and function-select widths.
//   ALU_F_*       : named function-select codes understood by alu.
//   alu_flags_t   : {cout, overflow, zero}, used by RTL and benches alike.
package alu_pkg;

    localparam int ALU_N = 32;
    localparam int ALU_M = 3;

    localparam logic [2:0] ALU_F_AND  = 3'b000;
    localparam logic [2:0] ALU_F_OR   = 3'b001;
    localparam logic [2:0] ALU_F_ADD  = 3'b010;
    localparam logic [2:0] ALU_F_XOR  = 3'b011;
    localparam logic [2:0] ALU_F_ANDN = 3'b100;
    localparam logic [2:0] ALU_F_ORN  = 3'b101;
    localparam logic [2:0] ALU_F_SUB  = 3'b110;
    localparam logic [2:0] ALU_F_XNOR = 3'b111;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request and response handshake bundle of alu_arbiter.
//   req_valid/req_ready : per-requester handshake (NREQ bits)
//   req_a/req_b/req_f   : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id, rsp_y, rsp_cout, rsp_overflow, rsp_zero : buffered result
//   op_count            : consumed-response counter
// Modport slave is the arbiter side, master the issue/consumer side.
interface alu_arbiter_if #(
    parameter int N    = 32,
    parameter int M    = 3,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*M-1:0] req_f;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_y;
    logic              rsp_cout;
    logic              rsp_overflow;
    logic              rsp_zero;
    logic [CNTW-1:0]   op_count;

    modport slave (
        input  req_valid, req_a, req_b, req_f, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_cout,
               rsp_overflow, rsp_zero, op_count
    );

    modport master (
        output req_valid, req_a, req_b, req_f, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_cout,
               rsp_overflow, rsp_zero, op_count
    );
endinterface

// File: rtl/alu.sv
// alu: combinational N-bit ALU.
//   a, b     : operands
//   f        : function select; f[2] inverts b, f[1:0] picks
//              AND / OR / SUM / XOR (SUM with f[2]=1 is a - b)
//   y        : result
//   cout     : adder carry out (0 for logic functions)
//   overflow : signed adder overflow (0 for logic functions)
//   zero     : y == 0
module alu
    import alu_pkg::*;
#(
    parameter int N = ALU_N,
    parameter int M = ALU_M
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [M-1:0] f,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);
    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic         arith;

    // Subtraction is a + ~b + 1: the inversion bit doubles as carry-in.
    assign b_eff = f[2] ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, f[2]};
    assign arith = (f[1:0] == 2'b10);

    always_comb begin
        y = '0;
        case (f[1:0])
            2'b00:   y = a & b_eff;
            2'b01:   y = a | b_eff;
            2'b10:   y = sum[N-1:0];
            default: y = a ^ b_eff;
        endcase
    end

    assign cout     = arith & sum[N];
    // Overflow: both adder inputs share a sign the result does not.
    assign overflow = arith & (a[N-1] == b_eff[N-1]) & (sum[N-1] != a[N-1]);
    assign zero     = (y == '0);
endmodule

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: round-robin one-hot arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : an accept happened this cycle; move pointer past winner
//   grant      : one-hot winner, search starts at the pointer and wraps
//   grant_idx  : index of the winner (0 when nothing requested)
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);
    logic [IDW-1:0] ptr_reg;

    always_comb begin
        int  j;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_reg) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu among NREQ requesters.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave -- request handshakes/operands in,
//           registered single-entry response (id, y, flags) out,
//           plus a counter of consumed responses.
// A round-robin grant selects one requester per cycle; when the response
// slot is free (empty or being consumed) the winner is accepted and its
// alu result is captured into the response register.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = ALU_N,
    parameter int M    = ALU_M,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            can_issue;
    logic            accept;

    logic [N-1:0] a_arr [NREQ];
    logic [N-1:0] b_arr [NREQ];
    logic [M-1:0] f_arr [NREQ];

    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [M-1:0] sel_f;

    logic [N-1:0] alu_y;
    alu_flags_t   alu_flags;
    logic         alu_cout;
    logic         alu_overflow;
    logic         alu_zero;

    logic            rsp_valid_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [N-1:0]    rsp_y_reg;
    alu_flags_t      rsp_flags_reg;
    logic [CNTW-1:0] op_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*N +: N];
            assign b_arr[gi] = bus.req_b[gi*N +: N];
            assign f_arr[gi] = bus.req_f[gi*M +: M];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The grant depends only on req_valid and the pointer, never on the
    // operands, so ready is stable while a requester holds its request.
    assign can_issue     = !rsp_valid_reg || bus.rsp_ready;
    assign bus.req_ready = (reset && can_issue) ? grant : '0;
    assign accept        = reset && can_issue && (|grant);

    assign sel_a = a_arr[grant_idx];
    assign sel_b = b_arr[grant_idx];
    assign sel_f = f_arr[grant_idx];

    alu #(
        .N (N),
        .M (M)
    ) u_alu (
        .a        (sel_a),
        .b        (sel_b),
        .f        (sel_f),
        .y        (alu_y),
        .cout     (alu_cout),
        .overflow (alu_overflow),
        .zero     (alu_zero)
    );

    assign alu_flags = '{cout: alu_cout, overflow: alu_overflow, zero: alu_zero};

    // Response buffer: a new accept overwrites it even on the consuming
    // edge, so back-to-back results flow without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_y_reg     <= '0;
            rsp_flags_reg <= '0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= grant_idx;
            rsp_y_reg     <= alu_y;
            rsp_flags_reg <= alu_flags;
        end else if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count_reg <= '0;
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            op_count_reg <= op_count_reg + 1'b1;
        end
    end

    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_id       = rsp_id_reg;
    assign bus.rsp_y        = rsp_y_reg;
    assign bus.rsp_cout     = rsp_flags_reg.cout;
    assign bus.rsp_overflow = rsp_flags_reg.overflow;
    assign bus.rsp_zero     = rsp_flags_reg.zero;
    assign bus.op_count     = op_count_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic for
// alu_arbiter, checked every cycle against a transaction-level model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N    = 32;
    localparam int M    = 3;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int CNTW = 4;

    logic clk;
    logic reset;

    alu_arbiter_if #(.N(N), .M(M), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();

    alu_arbiter #(.N(N), .M(M), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side stimulus
    logic [NREQ-1:0] vld;
    logic            rdy;
    logic [N-1:0]    op_a [NREQ];
    logic [N-1:0]    op_b [NREQ];
    logic [M-1:0]    op_f [NREQ];

    assign bus.req_valid = vld;
    assign bus.rsp_ready = rdy;
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_drive
            assign bus.req_a[gi*N +: N] = op_a[gi];
            assign bus.req_b[gi*N +: N] = op_b[gi];
            assign bus.req_f[gi*M +: M] = op_f[gi];
        end
    endgenerate

    // Reference model state
    int          m_ptr;
    logic        m_valid;
    int          m_id;
    logic [34:0] m_res;    // {y, cout, overflow, zero}
    int          m_cnt;
    int          last_acc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic stated directly in terms of integer value ranges.
    function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        logic [31:0] y;
        logic        c;
        logic        v;
        longint      s;
        y = '0; c = 1'b0; v = 1'b0; s = 0;
        case (f)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b011: y = a ^ b;
            3'b100: y = a & ~b;
            3'b101: y = a | ~b;
            3'b111: y = ~(a ^ b);
            3'b010: begin
                y = a + b;
                c = (longint'(a) + longint'(b)) > 64'sd4294967295;
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: begin
                y = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
        endcase
        return {y, c, v, (y == 32'd0)};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_id = 0; m_res = '0; m_cnt = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, then
    // return 1 time unit after the rising edge.
    task automatic cycle();
        int             pick;
        logic           can;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        pick      = rr_pick(vld, m_ptr);
        can       = !m_valid || rdy;
        exp_ready = '0;
        if (can && pick >= 0) exp_ready[pick] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        check("op_count", 64'(bus.op_count), 64'(m_cnt));
        if (m_valid) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            check("rsp_y", 64'(bus.rsp_y), 64'(m_res[34:3]));
            check("rsp_flags", 64'({bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero}),
                  64'(m_res[2:0]));
        end
        last_acc = -1;
        if (m_valid && rdy) m_cnt = (m_cnt + 1) % (1 << CNTW);
        if (exp_ready != '0) begin
            last_acc = pick;
            m_valid  = 1'b1;
            m_id     = pick;
            m_res    = alu_ref(op_a[pick], op_b[pick], op_f[pick]);
            m_ptr    = (pick + 1) % NREQ;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (last_acc >= 0) begin
            $display("txn: accept id=%0d a=%08h b=%08h f=%03b", last_acc,
                     op_a[last_acc], op_b[last_acc], op_f[last_acc]);
            vld[last_acc] = 1'b0;
        end
    endtask

    task automatic rand_op(input int i);
        op_a[i] = $urandom;
        case ($urandom_range(0, 3))
            0:       op_b[i] = op_a[i];
            1:       op_b[i] = 32'h8000_0000;
            default: op_b[i] = $urandom;
        endcase
        op_f[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic check_reset_zero();
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_y", 64'(bus.rsp_y), 64'd0);
        check("rst_rsp_flags", 64'({bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero}), 64'd0);
        check("rst_op_count", 64'(bus.op_count), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] stream_y [4];
    logic [2:0]  stream_f [4];
    int          prev_id;
    int          held_id;
    int          cnt_start;

    initial begin
        reset = 1'b0; vld = '0; rdy = 1'b0; last_acc = -1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_f[i] = '0;
        end
        model_reset();

        // Reset held, requests present: everything zero, no ready.
        repeat (2) @(posedge clk);
        #1;
        vld = 2'b11;
        #1;
        check_reset_zero();
        reset = 1'b1;
        vld   = '0;

        // Single requester: 5 + 3
        op_a[0] = 32'd5; op_b[0] = 32'd3; op_f[0] = ALU_F_ADD;
        vld = 2'b01; rdy = 1'b1;
        cycle();
        check("single_valid", 64'(bus.rsp_valid), 64'd1);
        check("single_id", 64'(bus.rsp_id), 64'd0);
        check("single_y", 64'(bus.rsp_y), 64'd8);
        check("single_flags", 64'({bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero}), 64'd0);
        cycle();
        check("single_count", 64'(bus.op_count), 64'd1);

        // Round-robin: pointer sits past id 0, so ids go 1,0,1,0,...
        op_a[0] = 32'd7;          op_b[0] = 32'd7; op_f[0] = ALU_F_SUB;
        op_a[1] = 32'h7FFF_FFFF;  op_b[1] = 32'd1; op_f[1] = ALU_F_ADD;
        prev_id = 0;
        for (int k = 0; k < 6; k++) begin
            vld = 2'b11;
            cycle();
            check("rr_id", 64'(bus.rsp_id), 64'(prev_id ^ 1));
            prev_id = prev_id ^ 1;
            if (prev_id == 0) begin
                check("rr_sub_y", 64'(bus.rsp_y), 64'd0);
                check("rr_sub_flags", 64'({bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero}),
                      64'(3'b101));
            end else begin
                check("rr_add_y", 64'(bus.rsp_y), 64'h8000_0000);
                check("rr_add_flags", 64'({bus.rsp_cout, bus.rsp_overflow, bus.rsp_zero}),
                      64'(3'b010));
            end
        end

        // Backpressure for three cycles with both requesters waiting.
        held_id = prev_id;
        vld = 2'b11; rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_ready", 64'(bus.req_ready), 64'd0);
            check("bp_id", 64'(bus.rsp_id), 64'(held_id));
            check("bp_y", 64'(bus.rsp_y), (held_id == 0) ? 64'd0 : 64'h8000_0000);
        end
        rdy = 1'b1;
        cycle();
        check("bp_release_id", 64'(bus.rsp_id), 64'(held_id ^ 1));

        // Requester 1 streams four logic ops at full rate.
        stream_f[0] = ALU_F_AND;  stream_y[0] = 32'hF000_F000;
        stream_f[1] = ALU_F_OR;   stream_y[1] = 32'hFFF0_FFF0;
        stream_f[2] = ALU_F_ANDN; stream_y[2] = 32'h00F0_00F0;
        stream_f[3] = ALU_F_ORN;  stream_y[3] = 32'hF0FF_F0FF;
        cnt_start = m_cnt;
        for (int k = 0; k < 4; k++) begin
            op_a[1] = 32'hF0F0_F0F0; op_b[1] = 32'hFF00_FF00; op_f[1] = stream_f[k];
            vld = 2'b10;
            cycle();
            check("stream_valid", 64'(bus.rsp_valid), 64'd1);
            check("stream_id", 64'(bus.rsp_id), 64'd1);
            check("stream_y", 64'(bus.rsp_y), 64'(stream_y[k]));
        end
        check("stream_count", 64'(bus.op_count), 64'((cnt_start + 4) % 16));
        vld = '0;

        // Counter wrap: 17 consumed responses on a 4-bit counter.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 17; k++) begin
            rand_op(0);
            vld = 2'b01;
            cycle();
        end
        vld = '0;
        cycle();
        check("wrap_count", 64'(bus.op_count), 64'd1);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] && $urandom_range(0, 3) != 0) begin
                    rand_op(i);
                    vld[i] = 1'b1;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset while a response is held.
        rand_op(0);
        vld = 2'b01; rdy = 1'b0;
        cycle();
        check("mid_valid_before", 64'(bus.rsp_valid), 64'd1);
        vld = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        check_reset_zero();
        reset = 1'b1;
        model_reset();
        vld = '0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] && $urandom_range(0, 1) != 0) begin
                    rand_op(i);
                    vld[i] = 1'b1;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
